// File: rtl/hex_digit_entry.sv
// hex_digit_entry
//   Collects hex digits from a 4-bit switch bank into an eight-nibble shift
//   register for a 7-segment display stage. Two raw push-buttons (enter,
//   clear) and the switches are synchronized; the buttons are optionally
//   debounced, and a press (rising edge of the debounced level) acts.
//
//   Build option: define HEX_ENTRY_DEBOUNCE_EN to build the per-button
//   debounce counters. Without it the synchronized level is used directly
//   and DEBOUNCE_CYCLES has no effect (latency 3 edges).
//
// Ports
//   clk_100MHz   in   system clock
//   rst_n        in   asynchronous active-low reset
//   val[3:0]     in   raw hex switch value
//   btn_enter    in   raw button: shift val into digits
//   btn_clear    in   raw button: clear all digits (wins over enter)
//   digits[31:0] out  eight nibbles, [3:0] is the rightmost digit
//   digit_count  out  number of digits entered, saturates at 8
//   full         out  digit_count == 8
//   entry_strobe out  one-cycle pulse whenever digits is updated
module hex_digit_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk_100MHz,
  input  logic        rst_n,
  input  logic [3:0]  val,
  input  logic        btn_enter,
  input  logic        btn_clear,
  output logic [31:0] digits,
  output logic [3:0]  digit_count,
  output logic        full,
  output logic        entry_strobe
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("hex_digit_entry: DEBOUNCE_CYCLES must be at least 1");
  end

  // Button index 0 = enter, 1 = clear.
  logic [3:0]  val_s1_q, val_s2_q;
  logic [1:0]  btn_s1_q, btn_s2_q;
  logic [1:0]  lvl;
  logic [1:0]  prev_q;
  logic [1:0]  press;
  logic [31:0] digits_q, digits_d;
  logic [3:0]  count_q, count_d;
  logic        strobe_q, strobe_d;

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      val_s1_q <= '0;
      val_s2_q <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
    end else begin
      val_s1_q <= val;
      val_s2_q <= val_s1_q;
      btn_s1_q <= {btn_clear, btn_enter};
      btn_s2_q <= btn_s1_q;
    end
  end

`ifdef HEX_ENTRY_DEBOUNCE_EN
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         lvl_q, lvl_d;

  // The counter only runs while the synchronized level disagrees with the
  // debounced level; any return to agreement (a bounce) restarts it.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (btn_s2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d[i] = btn_s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= '0;
      cnt_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign lvl = lvl_q;
`else
  assign lvl = btn_s2_q;
`endif

  // Press events only on 0->1 of the debounced level.
  assign press = lvl & ~prev_q;

  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    strobe_d = 1'b0;
    if (press[1]) begin
      digits_d = '0;
      count_d  = '0;
      strobe_d = 1'b1;
    end else if (press[0]) begin
      digits_d = {digits_q[27:0], val_s2_q};
      count_d  = (count_q == 4'd8) ? 4'd8 : count_q + 4'd1;
      strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '0;
      digits_q <= '0;
      count_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      prev_q   <= lvl;
      digits_q <= digits_d;
      count_q  <= count_d;
      strobe_q <= strobe_d;
    end
  end

  assign digits       = digits_q;
  assign digit_count  = count_q;
  assign full         = (count_q == 4'd8);
  assign entry_strobe = strobe_q;

endmodule

// File: tb/tb_hex_digit_entry.sv
module tb_hex_digit_entry;

  localparam int unsigned DB = 4;
`ifdef HEX_ENTRY_DEBOUNCE_EN
  localparam int unsigned LAT = DB + 3;
`else
  localparam int unsigned LAT = 3;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  val;
  logic        btn_enter;
  logic        btn_clear;
  logic [31:0] digits;
  logic [3:0]  digit_count;
  logic        full;
  logic        entry_strobe;

  int tests;
  int fails;
  int strobes;

  hex_digit_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk_100MHz   (clk),
    .rst_n        (rst_n),
    .val          (val),
    .btn_enter    (btn_enter),
    .btn_clear    (btn_clear),
    .digits       (digits),
    .digit_count  (digit_count),
    .full         (full),
    .entry_strobe (entry_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (entry_strobe === 1'b1) strobes++;

  // Stimulus only: hold the given buttons for 'hold' cycles, release, settle.
  task automatic press_btn(input logic en, input logic cl, input logic [3:0] v, input int hold);
    @(negedge clk);
    val = v; btn_enter = en; btn_clear = cl;
    repeat (hold) @(negedge clk);
    btn_enter = 1'b0; btn_clear = 1'b0;
    repeat (LAT + 3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; val = '0; btn_enter = 1'b0; btn_clear = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (digits !== 32'h0) begin fails++; $display("FAIL reset_digits got %h want %h", digits, 32'h0); end
    tests++; if (digit_count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", digit_count); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", full); end
    tests++; if (entry_strobe !== 1'b0) begin fails++; $display("FAIL reset_strobe got %b want 0", entry_strobe); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    int s0;
    s0 = strobes;
    @(negedge clk);
    val = 4'hA; btn_enter = 1'b1;
    for (int e = 1; e <= int'(LAT); e++) begin
      @(posedge clk); #1;
      if (e == int'(LAT) - 1) begin
        tests++; if (digits !== 32'h0 || entry_strobe !== 1'b0) begin
          fails++; $display("FAIL latency_early edge %0d got digits=%h strobe=%b want 0/0", e, digits, entry_strobe); end
      end
      if (e == int'(LAT)) begin
        tests++; if (digits !== 32'h0000000A) begin fails++; $display("FAIL latency_digits got %h want %h", digits, 32'hA); end
        tests++; if (entry_strobe !== 1'b1) begin fails++; $display("FAIL latency_strobe got %b want 1", entry_strobe); end
        tests++; if (digit_count !== 4'd1) begin fails++; $display("FAIL latency_count got %0d want 1", digit_count); end
      end
    end
    repeat (20 - LAT) @(negedge clk);
    btn_enter = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    tests++; if (strobes - s0 !== 1) begin fails++; $display("FAIL latency_strobes got %0d want 1", strobes - s0); end
    tests++; if (digits !== 32'h0000000A) begin fails++; $display("FAIL release_no_event got %h want %h", digits, 32'hA); end
  endtask

  task automatic test_fill();
    int s0;
    press_btn(1'b0, 1'b1, 4'h0, 12);
    tests++; if (digits !== 32'h0 || digit_count !== 4'd0) begin
      fails++; $display("FAIL clear got digits=%h count=%0d want 0/0", digits, digit_count); end
    s0 = strobes;
    for (int k = 1; k <= 9; k++) begin
      press_btn(1'b1, 1'b0, 4'(k), 12);
      if (k == 7) begin
        tests++; if (full !== 1'b0 || digit_count !== 4'd7) begin
          fails++; $display("FAIL fill7 got full=%b count=%0d want 0/7", full, digit_count); end
      end
      if (k == 8) begin
        tests++; if (digits !== 32'h12345678 || full !== 1'b1) begin
          fails++; $display("FAIL fill8 got digits=%h full=%b want 12345678/1", digits, full); end
      end
    end
    tests++; if (digits !== 32'h23456789) begin fails++; $display("FAIL fill9_digits got %h want %h", digits, 32'h23456789); end
    tests++; if (digit_count !== 4'd8) begin fails++; $display("FAIL fill9_count got %0d want 8", digit_count); end
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL fill9_full got %b want 1", full); end
    tests++; if (strobes - s0 !== 9) begin fails++; $display("FAIL fill_strobes got %0d want 9", strobes - s0); end
  endtask

`ifdef HEX_ENTRY_DEBOUNCE_EN
  task automatic test_bounce();
    int s0;
    s0 = strobes;
    @(negedge clk);
    val = 4'hF;
    for (int t = 0; t < 15; t++) begin
      btn_enter = ~btn_enter;
      repeat (2) @(negedge clk);
    end
    btn_enter = 1'b0;
    repeat (LAT + 5) @(negedge clk);
    tests++; if (digits !== 32'h23456789 || digit_count !== 4'd8) begin
      fails++; $display("FAIL bounce_state got digits=%h count=%0d want 23456789/8", digits, digit_count); end
    tests++; if (strobes - s0 !== 0) begin fails++; $display("FAIL bounce_strobes got %0d want 0", strobes - s0); end
  endtask
`endif

  task automatic test_clear_enter();
    int s0;
    s0 = strobes;
    press_btn(1'b1, 1'b1, 4'hE, 20);
    tests++; if (digits !== 32'h0) begin fails++; $display("FAIL both_digits got %h want 0", digits); end
    tests++; if (digit_count !== 4'd0) begin fails++; $display("FAIL both_count got %0d want 0", digit_count); end
    tests++; if (strobes - s0 !== 1) begin fails++; $display("FAIL both_strobes got %0d want 1", strobes - s0); end
  endtask

  task automatic test_reset_mid();
    int s0;
    press_btn(1'b1, 1'b0, 4'h3, 12);
    tests++; if (digits !== 32'h3) begin fails++; $display("FAIL pre_mid got %h want 3", digits); end
    @(negedge clk);
    val = 4'h9; btn_enter = 1'b1;
    repeat (LAT - 2) @(negedge clk);
    rst_n = 1'b0; btn_enter = 1'b0;
    #1;
    tests++; if (digits !== 32'h0 || digit_count !== 4'd0 || full !== 1'b0 || entry_strobe !== 1'b0) begin
      fails++; $display("FAIL mid_reset got digits=%h count=%0d full=%b strobe=%b want all 0",
                        digits, digit_count, full, entry_strobe); end
    @(negedge clk);
    rst_n = 1'b1;
    s0 = strobes;
    repeat (20) @(negedge clk);
    tests++; if (strobes - s0 !== 0 || digits !== 32'h0) begin
      fails++; $display("FAIL mid_no_event got strobes=%0d digits=%h want 0/0", strobes - s0, digits); end
    press_btn(1'b1, 1'b0, 4'h6, 12);
    tests++; if (digits !== 32'h6 || digit_count !== 4'd1) begin
      fails++; $display("FAIL mid_repress got digits=%h count=%0d want 6/1", digits, digit_count); end
  endtask

  task automatic test_held_through_reset();
    @(negedge clk);
    rst_n = 1'b0; val = 4'hC; btn_enter = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    btn_enter = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    tests++; if (digits !== 32'hC || digit_count !== 4'd1) begin
      fails++; $display("FAIL held_reset got digits=%h count=%0d want C/1", digits, digit_count); end
  endtask

  initial begin
    tests = 0; fails = 0; strobes = 0;
    test_reset();
    test_latency();
    test_fill();
`ifdef HEX_ENTRY_DEBOUNCE_EN
    test_bounce();
`endif
    test_clear_enter();
    test_reset_mid();
    test_held_through_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
